crop_window_out: RTL and testbench

Pixel-stream cropper at the far end of the Y-start detection path. It consumes the same 640x480, 10-bit raw pixel stream as the Y-start detector and takes the detector's Y start value. It emits only the pixels inside a fixed-size crop window whose top row tracks that Y start, with line and frame markers for the downstream capture buffer. The window position is latched once per frame, so a frame is never cropped with two different origins.

---
 rtl/crop_window_out.sv | 159 +++++++++++++++
 tb/tb_crop_window_out.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/crop_window_out.sv
// Crops a fixed-size window out of a raw pixel stream; the window top row follows
// the Y-start detector and is latched once per frame at pixel (0,0).
module crop_window_out #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int X_START  = 160,
  parameter int CROP_W   = 320,
  parameter int CROP_H   = 240
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [9:0]  iDATA,
  input  logic        iDVAL,
  input  logic [15:0] iYSTART,
  input  logic        iCROP_EN,
  output logic [9:0]  oDATA,
  output logic        oDVAL,
  output logic        oSOL,
  output logic        oEOL,
  output logic        oSOF,
  output logic        oEOF,
  output logic [15:0] oYORG
);

  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] X_FIRST  = 16'(X_START);
  localparam logic [15:0] WIN_W    = 16'(CROP_W);
  localparam logic [15:0] WIN_H    = 16'(CROP_H);
  localparam logic [15:0] YORG_MAX = 16'(V_ACTIVE - CROP_H);

  typedef enum logic [2:0] {
    ARM        = 3'd0,
    IDLE_FRAME = 3'd1,
    SKIP       = 3'd2,
    ACTIVE     = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t      stateR;
  logic [15:0] xContR;
  logic [15:0] yContR;

  logic        isOriginS;
  logic [15:0] yorgSelS;
  logic        frameOnS;
  logic [15:0] xOffS;
  logic [15:0] yOffS;
  logic        emitS;
  logic        isSolS;
  logic        isEolS;
  logic        isSofS;
  logic        isEofS;

  // Window decode for the pixel currently on the input, using the origin that
  // will be in force for it (freshly clamped at (0,0), otherwise the latched one).
  always_comb begin
    isOriginS = (xContR == 16'd0) && (yContR == 16'd0);
    if (isOriginS) begin
      yorgSelS = (iYSTART > YORG_MAX) ? YORG_MAX : iYSTART;
      frameOnS = iCROP_EN;
    end else begin
      yorgSelS = oYORG;
      frameOnS = (stateR == SKIP) || (stateR == ACTIVE);
    end
    // Offsets wrap to large values below the window, so one compare covers both edges
    xOffS  = xContR - X_FIRST;
    yOffS  = yContR - yorgSelS;
    emitS  = iDVAL && frameOnS && (xOffS < WIN_W) && (yOffS < WIN_H);
    isSolS = (xOffS == 16'd0);
    isEolS = (xOffS == WIN_W - 16'd1);
    isSofS = isSolS && (yOffS == 16'd0);
    isEofS = isEolS && (yOffS == WIN_H - 16'd1);
  end

  // Raster position of the incoming pixel; advances only on valid pixels.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      xContR <= 16'd0;
      yContR <= 16'd0;
    end else if (iDVAL) begin
      if (xContR == X_LAST) begin
        xContR <= 16'd0;
        yContR <= (yContR == Y_LAST) ? 16'd0 : yContR + 16'd1;
      end else begin
        xContR <= xContR + 16'd1;
      end
    end else begin
      xContR <= xContR;
      yContR <= yContR;
    end
  end

  // Frame state machine with registered pixel and marker outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stateR <= ARM;
      oDATA  <= 10'd0;
      oDVAL  <= 1'b0;
      oSOL   <= 1'b0;
      oEOL   <= 1'b0;
      oSOF   <= 1'b0;
      oEOF   <= 1'b0;
      oYORG  <= 16'd0;
    end else if (iDVAL) begin
      oDVAL <= emitS;
      oSOL  <= emitS && isSolS;
      oEOL  <= emitS && isEolS;
      oSOF  <= emitS && isSofS;
      oEOF  <= emitS && isEofS;
      if (emitS) begin
        oDATA <= iDATA;
      end else begin
        oDATA <= oDATA;
      end
      if (isOriginS) begin
        oYORG <= yorgSelS;
        if (!iCROP_EN) begin
          stateR <= IDLE_FRAME;
        end else if (emitS && isEofS) begin
          stateR <= DONE;
        end else if (emitS) begin
          stateR <= ACTIVE;
        end else begin
          stateR <= SKIP;
        end
      end else begin
        oYORG <= oYORG;
        case (stateR)
          SKIP: begin
            if (emitS) begin
              stateR <= isEofS ? DONE : ACTIVE;
            end else begin
              stateR <= SKIP;
            end
          end
          ACTIVE: begin
            if (emitS && isEofS) begin
              stateR <= DONE;
            end else begin
              stateR <= ACTIVE;
            end
          end
          default: stateR <= stateR;
        endcase
      end
    end else begin
      stateR <= stateR;
      oDATA  <= oDATA;
      oDVAL  <= 1'b0;
      oSOL   <= 1'b0;
      oEOL   <= 1'b0;
      oSOF   <= 1'b0;
      oEOF   <= 1'b0;
      oYORG  <= oYORG;
    end
  end

endmodule

// File: tb/tb_crop_window_out.sv
// Randomized bench for crop_window_out on a reduced raster; two instances differ
// only in X_START so that the window touching pixel (0,0) is also covered.
module tb_crop_window_out;

  localparam int H    = 16;
  localparam int V    = 12;
  localparam int CW   = 8;
  localparam int CH   = 6;
  localparam int XS_A = 4;
  localparam int XS_B = 0;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [9:0]  iDATA = 10'd0;
  logic        iDVAL = 1'b0;
  logic [15:0] iYSTART = 16'd0;
  logic        iCROP_EN = 1'b0;

  logic [1:0][9:0]  oData;
  logic [1:0]       oDval, oSol, oEol, oSof, oEof;
  logic [1:0][15:0] oYorg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // reference model state
  int               mIdx = 0;
  logic [15:0]      mYorg = 16'd0;
  logic             mEn = 1'b0;
  logic [1:0]       eDval = 2'b00, eSol = 2'b00, eEol = 2'b00, eSof = 2'b00, eEof = 2'b00;
  logic [1:0][9:0]  eData = '0;

  crop_window_out #(.H_ACTIVE(H), .V_ACTIVE(V), .X_START(XS_A), .CROP_W(CW), .CROP_H(CH)) dutA (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iYSTART(iYSTART), .iCROP_EN(iCROP_EN),
    .oDATA(oData[0]), .oDVAL(oDval[0]), .oSOL(oSol[0]), .oEOL(oEol[0]), .oSOF(oSof[0]),
    .oEOF(oEof[0]), .oYORG(oYorg[0]));

  crop_window_out #(.H_ACTIVE(H), .V_ACTIVE(V), .X_START(XS_B), .CROP_W(CW), .CROP_H(CH)) dutB (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iYSTART(iYSTART), .iCROP_EN(iCROP_EN),
    .oDATA(oData[1]), .oDVAL(oDval[1]), .oSOL(oSol[1]), .oEOL(oEol[1]), .oSOF(oSof[1]),
    .oEOF(oEof[1]), .oYORG(oYorg[1]));

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      chk("oDVAL", k, 16'(oDval[k]), 16'(eDval[k]));
      chk("oSOL",  k, 16'(oSol[k]),  16'(eSol[k]));
      chk("oEOL",  k, 16'(oEol[k]),  16'(eEol[k]));
      chk("oSOF",  k, 16'(oSof[k]),  16'(eSof[k]));
      chk("oEOF",  k, 16'(oEof[k]),  16'(eEof[k]));
      chk("oDATA", k, 16'(oData[k]), 16'(eData[k]));
      chk("oYORG", k, oYorg[k], mYorg);
    end
  endtask

  task automatic modelReset();
    mIdx  = 0;
    mYorg = 16'd0;
    mEn   = 1'b0;
    eDval = 2'b00; eSol = 2'b00; eEol = 2'b00; eSof = 2'b00; eEof = 2'b00;
    eData = '0;
  endtask

  // One clock: present a pixel (or gap), predict from raster position, check after the edge.
  task automatic step(input logic dv, input logic [9:0] d);
    int x, y, xs, yo;
    iDVAL = dv;
    iDATA = d;
    if (dv) begin
      x = mIdx % H;
      y = mIdx / H;
      if (mIdx == 0) begin
        mYorg = (iYSTART > 16'(V - CH)) ? 16'(V - CH) : iYSTART;
        mEn   = iCROP_EN;
      end
      yo = int'(mYorg);
      for (int k = 0; k < 2; k++) begin
        xs = (k == 0) ? XS_A : XS_B;
        eDval[k] = mEn && (x >= xs) && (x < xs + CW) && (y >= yo) && (y < yo + CH);
        eSol[k]  = eDval[k] && (x == xs);
        eEol[k]  = eDval[k] && (x == xs + CW - 1);
        eSof[k]  = eSol[k] && (y == yo);
        eEof[k]  = eEol[k] && (y == yo + CH - 1);
        if (eDval[k]) eData[k] = d;
      end
      mIdx = (mIdx + 1) % (H * V);
    end else begin
      eDval = 2'b00; eSol = 2'b00; eEol = 2'b00; eSof = 2'b00; eEof = 2'b00;
    end
    @(posedge iCLK);
    #1;
    if (oDval[0]) pulses++;
    checkAll();
  endtask

  // Feed nPix valid pixels with random gaps; at valid pixel chgAt switch Y start / enable.
  task automatic frame(input int gapPct, input int chgAt, input logic [15:0] newY,
                       input logic newEn, input int nPix);
    int n;
    n = 0;
    while (n < nPix) begin
      if (n == chgAt) begin
        iYSTART  = newY;
        iCROP_EN = newEn;
      end
      if (int'($urandom_range(99)) < gapPct) begin
        step(1'b0, 10'($urandom));
      end else begin
        step(1'b1, 10'($urandom));
        n++;
      end
    end
  endtask

  initial begin
    // reset state
    modelReset();
    repeat (2) @(posedge iCLK);
    #1;
    checkAll();
    @(negedge iCLK);
    iRST = 1'b1;

    // basic crop
    iYSTART = 16'd5; iCROP_EN = 1'b1; pulses = 0;
    frame(0, -1, 16'd0, 1'b0, H * V);
    chk("pulses_basic", 0, 16'(pulses), 16'(CW * CH));

    // clamp: both beyond the limit land on V-CH
    iYSTART = 16'd9;
    frame(0, -1, 16'd0, 1'b0, H * V);
    iYSTART = 16'hFFFF;
    frame(0, -1, 16'd0, 1'b0, H * V);

    // mid-frame Y start change applies only from the next frame
    iYSTART = 16'd2;
    frame(0, 4 * H, 16'd5, 1'b1, H * V);
    frame(0, -1, 16'd0, 1'b0, H * V);

    // origin row 0: window of dutB starts on pixel (0,0)
    iYSTART = 16'd0;
    frame(0, -1, 16'd0, 1'b0, H * V);

    // stalls
    iYSTART = 16'd5; pulses = 0;
    frame(50, -1, 16'd0, 1'b0, H * V);
    chk("pulses_stall", 0, 16'(pulses), 16'(CW * CH));

    // disabled frame, then enable raised mid-frame
    iCROP_EN = 1'b0; pulses = 0;
    frame(20, -1, 16'd0, 1'b0, H * V);
    chk("pulses_off", 0, 16'(pulses), 16'd0);
    frame(0, 5 * H, 16'd3, 1'b1, H * V);
    chk("pulses_raise", 0, 16'(pulses), 16'd0);
    frame(10, -1, 16'd0, 1'b0, H * V);
    chk("pulses_after", 0, 16'(pulses), 16'(CW * CH));

    // reset in the middle of an active crop
    iYSTART = 16'd3; iCROP_EN = 1'b1;
    frame(10, -1, 16'd0, 1'b0, 5 * H + 6);
    iDVAL = 1'b0;
    iRST  = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(posedge iCLK);
    #1;
    checkAll();
    @(negedge iCLK);
    iRST = 1'b1;
    pulses = 0;
    frame(30, -1, 16'd0, 1'b0, H * V);
    chk("pulses_rst", 0, 16'(pulses), 16'(CW * CH));

    // random origins, enables and gap rates
    repeat (4) begin
      iYSTART  = 16'($urandom_range(0, 10));
      iCROP_EN = 1'($urandom_range(0, 3) != 0);
      frame(int'($urandom_range(0, 40)), int'($urandom_range(0, H * V - 1)),
            16'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), H * V);
    end

    step(1'b0, 10'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
